multicycle_controller: RTL and testbench

- Sequencing FSM for the multicycle RV32I core. It replaces the single-cycle combinational main decoder.
- Drives the shared datapath one step per state: one ALU, one unified instruction/data memory port, and the IR, OldPC, A, B and ALUOut registers.
- Stalls on a ready/request memory handshake.
- Resolves branches from the ALU flags and flags illegal opcodes.

---
 rtl/multicycle_controller.sv | 220 ++++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// Sequencing FSM for the multicycle RV32I core: one datapath step per state,
// memory ready/request stalls, branch resolution from ALU flags, illegal-op trap.
module multicycle_controller #(
  parameter bit RESET_PC_WRITE = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       Zero,
  input  logic       ALUR31,
  input  logic       ALU_Carry,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] imm_src,
  output logic       retire,
  output logic       illegal
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALR     = 4'd11,
    S_JLINK    = 4'd12,
    S_UPPER    = 4'd13,
    S_TRAP     = 4'd14
  } state_t;

  state_t r_state;
  state_t w_next;
  state_t w_decode_next;
  logic   r_boot;
  logic   w_take;
  logic   w_bad_f3;

  // r_boot masks every strobe in the first cycle after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
      r_boot  <= 1'b1;
    end else begin
      r_state <= w_next;
      r_boot  <= 1'b0;
    end
  end

  always_comb begin
    imm_src = 2'b00;
    case (op)
      7'b0100011: imm_src = 2'b01;
      7'b1100011: imm_src = 2'b10;
      7'b1101111: imm_src = 2'b11;
      default:    imm_src = 2'b00;
    endcase
  end

  always_comb begin
    w_decode_next = S_TRAP;
    case (op)
      7'b0000011, 7'b0100011: w_decode_next = S_MEMADR;
      7'b0110011:             w_decode_next = S_EXECR;
      7'b0010011:             w_decode_next = S_EXECI;
      7'b1100011:             w_decode_next = S_BRANCH;
      7'b1101111:             w_decode_next = S_JAL;
      7'b1100111:             w_decode_next = S_JALR;
      7'b0110111, 7'b0010111: w_decode_next = S_UPPER;
      default:                w_decode_next = S_TRAP;
    endcase
  end

  always_comb begin
    w_take   = 1'b0;
    w_bad_f3 = 1'b0;
    case (funct3)
      3'b000:  w_take = Zero;
      3'b001:  w_take = !Zero;
      3'b100:  w_take = ALUR31;
      3'b101:  w_take = !ALUR31;
      3'b110:  w_take = ALU_Carry;
      3'b111:  w_take = !ALU_Carry;
      default: w_bad_f3 = 1'b1;
    endcase
  end

  assign illegal = (r_state == S_TRAP);

  // Strobes depend on the current state plus mem_ready and branch flags.
  always_comb begin
    w_next     = r_state;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    result_src = 2'b00;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    retire     = 1'b0;
    if (r_boot) begin
      w_next   = S_FETCH;
      pc_write = RESET_PC_WRITE && rst_n;
    end else begin
      case (r_state)
        S_FETCH: begin
          mem_req = 1'b1;
          if (mem_ready) begin
            ir_write   = 1'b1;
            alu_src_b  = 2'b10;
            result_src = 2'b10;
            pc_write   = 1'b1;
            w_next     = S_DECODE;
          end
        end
        S_DECODE: begin
          alu_src_a = 2'b01;
          alu_src_b = 2'b01;
          w_next    = w_decode_next;
        end
        S_MEMADR: begin
          alu_src_a = 2'b10;
          alu_src_b = 2'b01;
          w_next    = op[5] ? S_MEMWRITE : S_MEMREAD;
        end
        S_MEMREAD: begin
          mem_req = 1'b1;
          adr_src = 1'b1;
          if (mem_ready) w_next = S_MEMWB;
        end
        S_MEMWB: begin
          result_src = 2'b01;
          reg_write  = 1'b1;
          retire     = 1'b1;
          w_next     = S_FETCH;
        end
        S_MEMWRITE: begin
          mem_req = 1'b1;
          mem_we  = 1'b1;
          adr_src = 1'b1;
          if (mem_ready) begin
            retire = 1'b1;
            w_next = S_FETCH;
          end
        end
        S_EXECR: begin
          alu_src_a = 2'b10;
          alu_op    = 2'b10;
          w_next    = S_ALUWB;
        end
        S_EXECI: begin
          alu_src_a = 2'b10;
          alu_src_b = 2'b01;
          alu_op    = 2'b10;
          w_next    = S_ALUWB;
        end
        S_ALUWB: begin
          reg_write = 1'b1;
          retire    = 1'b1;
          w_next    = S_FETCH;
        end
        S_BRANCH: begin
          alu_src_a = 2'b10;
          alu_op    = 2'b01;
          retire    = 1'b1;
          pc_write  = w_take;
          w_next    = w_bad_f3 ? S_TRAP : S_FETCH;
        end
        S_JAL: begin
          alu_src_a = 2'b01;
          alu_src_b = 2'b10;
          pc_write  = 1'b1;
          w_next    = S_ALUWB;
        end
        S_JALR: begin
          alu_src_a  = 2'b10;
          alu_src_b  = 2'b01;
          result_src = 2'b10;
          pc_write   = 1'b1;
          w_next     = S_JLINK;
        end
        S_JLINK: begin
          alu_src_a  = 2'b01;
          alu_src_b  = 2'b10;
          result_src = 2'b10;
          reg_write  = 1'b1;
          retire     = 1'b1;
          w_next     = S_FETCH;
        end
        S_UPPER: begin
          result_src = 2'b11;
          reg_write  = 1'b1;
          retire     = 1'b1;
          w_next     = S_FETCH;
        end
        S_TRAP:  w_next = S_TRAP;
        default: w_next = S_TRAP;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: per-instruction cycle schedules
// built from the instruction-class rules, with random waits, flags and noise.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [6:0] op = 7'b0;
  logic [2:0] funct3 = 3'b0;
  logic       Zero = 1'b0, ALUR31 = 1'b0, ALU_Carry = 1'b0, mem_ready = 1'b0;
  logic       mem_req, mem_we, adr_src, ir_write, pc_write, reg_write, retire, illegal;
  logic [1:0] result_src, alu_src_a, alu_src_b, alu_op, imm_src;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic req, we, adr, irw, pcw, rw;
    logic [1:0] rs, sa, sb, aop;
    logic ret, ill;
  } ctl_t;

  typedef struct packed {
    logic ready;
    ctl_t exp;
  } step_t;

  localparam int C_LOAD = 0, C_STORE = 1, C_R = 2, C_I = 3, C_BR = 4, C_JAL = 5,
                 C_JALR = 6, C_LUI = 7, C_AUIPC = 8, C_BAD = 9;

  step_t sched[$];
  ctl_t  obs;

  assign obs = {mem_req, mem_we, adr_src, ir_write, pc_write, reg_write,
                result_src, alu_src_a, alu_src_b, alu_op, retire, illegal};

  multicycle_controller #(.RESET_PC_WRITE(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .Zero(Zero),
    .ALUR31(ALUR31), .ALU_Carry(ALU_Carry), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .adr_src(adr_src), .ir_write(ir_write),
    .pc_write(pc_write), .reg_write(reg_write), .result_src(result_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .imm_src(imm_src), .retire(retire), .illegal(illegal)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] op_of(input int cls);
    case (cls)
      C_LOAD:  return 7'b0000011;
      C_STORE: return 7'b0100011;
      C_R:     return 7'b0110011;
      C_I:     return 7'b0010011;
      C_BR:    return 7'b1100011;
      C_JAL:   return 7'b1101111;
      C_JALR:  return 7'b1100111;
      C_LUI:   return 7'b0110111;
      C_AUIPC: return 7'b0010111;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [1:0] imm_of(input int cls);
    case (cls)
      C_STORE: return 2'b01;
      C_BR:    return 2'b10;
      C_JAL:   return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic take_of(input logic [2:0] f3, input logic z, n, c);
    case (f3)
      3'b000:  return z;
      3'b001:  return !z;
      3'b100:  return n;
      3'b101:  return !n;
      3'b110:  return c;
      3'b111:  return !c;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic rnd_bit();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic push(input logic r, input ctl_t e);
    sched.push_back({r, e});
  endtask

  task automatic check(input string tag, input ctl_t o, input ctl_t e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic check_imm(input string tag, input logic [1:0] o, input logic [1:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s imm_src observed=%b expected=%b", tag, o, e);
    end
  endtask

  // Expected cycle-by-cycle strobes for one instruction starting in FETCH.
  task automatic build(input int cls, input logic [2:0] f3, input logic z, n, c,
                       input int fw, input int mw);
    ctl_t e;
    sched.delete();
    repeat (fw) begin e = '0; e.req = 1'b1; push(1'b0, e); end
    e = '0; e.req = 1'b1; e.irw = 1'b1; e.pcw = 1'b1; e.rs = 2'b10; e.sb = 2'b10;
    push(1'b1, e);
    e = '0; e.sa = 2'b01; e.sb = 2'b01; push(rnd_bit(), e);
    case (cls)
      C_LOAD, C_STORE: begin
        e = '0; e.sa = 2'b10; e.sb = 2'b01; push(rnd_bit(), e);
        repeat (mw) begin
          e = '0; e.req = 1'b1; e.adr = 1'b1; e.we = (cls == C_STORE); push(1'b0, e);
        end
        e = '0; e.req = 1'b1; e.adr = 1'b1;
        if (cls == C_STORE) begin e.we = 1'b1; e.ret = 1'b1; end
        push(1'b1, e);
        if (cls == C_LOAD) begin
          e = '0; e.rs = 2'b01; e.rw = 1'b1; e.ret = 1'b1; push(rnd_bit(), e);
        end
      end
      C_R, C_I: begin
        e = '0; e.sa = 2'b10; e.sb = (cls == C_I) ? 2'b01 : 2'b00; e.aop = 2'b10;
        push(rnd_bit(), e);
        e = '0; e.rw = 1'b1; e.ret = 1'b1; push(rnd_bit(), e);
      end
      C_BR: begin
        e = '0; e.sa = 2'b10; e.aop = 2'b01; e.ret = 1'b1; e.pcw = take_of(f3, z, n, c);
        push(rnd_bit(), e);
        if (f3 == 3'b010 || f3 == 3'b011)
          repeat (3) begin e = '0; e.ill = 1'b1; push(rnd_bit(), e); end
      end
      C_JAL: begin
        e = '0; e.sa = 2'b01; e.sb = 2'b10; e.pcw = 1'b1; push(rnd_bit(), e);
        e = '0; e.rw = 1'b1; e.ret = 1'b1; push(rnd_bit(), e);
      end
      C_JALR: begin
        e = '0; e.sa = 2'b10; e.sb = 2'b01; e.rs = 2'b10; e.pcw = 1'b1; push(rnd_bit(), e);
        e = '0; e.sa = 2'b01; e.sb = 2'b10; e.rs = 2'b10; e.rw = 1'b1; e.ret = 1'b1;
        push(rnd_bit(), e);
      end
      C_LUI, C_AUIPC: begin
        e = '0; e.rs = 2'b11; e.rw = 1'b1; e.ret = 1'b1; push(rnd_bit(), e);
      end
      default: begin
        repeat (3) begin e = '0; e.ill = 1'b1; push(rnd_bit(), e); end
      end
    endcase
  endtask

  // Drive inputs at negedge, sample 1ns later; stop after 'limit' steps.
  task automatic run(input string tag, input int cls, input logic [2:0] f3,
                     input logic z, n, c, input int limit);
    step_t s;
    int k;
    k = 0;
    while (sched.size() > 0 && k < limit) begin
      s = sched.pop_front();
      @(negedge clk);
      op = op_of(cls); funct3 = f3; Zero = z; ALUR31 = n; ALU_Carry = c;
      mem_ready = s.ready;
      #1;
      check($sformatf("%s step%0d", tag, k), obs, s.exp);
      check_imm($sformatf("%s step%0d", tag, k), imm_src, imm_of(cls));
      k++;
    end
    sched.delete();
  endtask

  task automatic instr(input string tag, input int cls, input logic [2:0] f3,
                       input logic z, n, c, input int fw, input int mw);
    build(cls, f3, z, n, c, fw, mw);
    run(tag, cls, f3, z, n, c, 1000);
  endtask

  // Assert reset now, then release at the next negedge; both phases are silent.
  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    mem_ready = 1'b1;
    #1;
    check({tag, " in-reset"}, obs, '0);
    @(negedge clk);
    rst_n = 1'b1;
    mem_ready = 1'b1;
    #1;
    check({tag, " post-release"}, obs, '0);
  endtask

  logic [2:0] br_f3 [6];

  initial begin
    br_f3[0] = 3'b000; br_f3[1] = 3'b001; br_f3[2] = 3'b100;
    br_f3[3] = 3'b101; br_f3[4] = 3'b110; br_f3[5] = 3'b111;
    #2;
    do_reset("reset");

    instr("add", C_R, 3'b000, 1'b0, 1'b0, 1'b0, 0, 0);
    instr("lw_stall", C_LOAD, 3'b010, 1'b0, 1'b0, 1'b0, 3, 3);
    instr("beq_z1", C_BR, 3'b000, 1'b1, 1'b0, 1'b0, 0, 0);
    instr("bne_z1", C_BR, 3'b001, 1'b1, 1'b0, 1'b0, 0, 0);
    instr("bltu_c1", C_BR, 3'b110, 1'b0, 1'b0, 1'b1, 0, 0);
    instr("bge_n1", C_BR, 3'b101, 1'b0, 1'b1, 1'b0, 0, 0);
    instr("jalr", C_JALR, 3'b000, 1'b0, 1'b0, 1'b0, 0, 0);
    instr("jal", C_JAL, 3'b000, 1'b0, 1'b0, 1'b0, 1, 0);
    instr("sw", C_STORE, 3'b010, 1'b0, 1'b0, 1'b0, 0, 2);
    instr("lui", C_LUI, 3'b000, 1'b0, 1'b0, 1'b0, 0, 0);
    instr("addi", C_I, 3'b000, 1'b0, 1'b0, 1'b0, 2, 0);

    instr("illegal_op", C_BAD, 3'b000, 1'b0, 1'b0, 1'b0, 0, 0);
    do_reset("reset_after_trap");
    instr("add_after_trap", C_R, 3'b000, 1'b0, 1'b0, 1'b0, 0, 0);

    // Store stalled in MEMWRITE: reset mid-cycle must drop mem_req/mem_we at once.
    build(C_STORE, 3'b010, 1'b0, 1'b0, 1'b0, 0, 5);
    run("sw_reset", C_STORE, 3'b010, 1'b0, 1'b0, 1'b0, 5);
    do_reset("reset_mid_write");
    instr("auipc_after_reset", C_AUIPC, 3'b000, 1'b0, 1'b0, 1'b0, 0, 0);

    for (int i = 0; i < 60; i++) begin
      int cls;
      logic [2:0] f3;
      cls = int'($urandom_range(0, 8));
      f3 = (cls == C_BR) ? br_f3[$urandom_range(0, 5)] : 3'($urandom_range(0, 7));
      instr($sformatf("rand%0d", i), cls, f3, rnd_bit(), rnd_bit(), rnd_bit(),
            int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
    end

    instr("bad_branch_f3", C_BR, 3'b011, 1'b1, 1'b1, 1'b1, 0, 0);
    do_reset("reset_after_bad_branch");
    instr("final_add", C_R, 3'b000, 1'b0, 1'b0, 1'b0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
